// File: rtl/input_debounce_conditioner_if.sv
// rtl/input_debounce_conditioner_if.sv - raw pin inputs and debounced level/strobe outputs
interface input_debounce_conditioner_if #(
    parameter int NUM_BTN = 4,
    parameter int NUM_SW  = 4
);
    logic [NUM_BTN-1:0] key_n_raw;
    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_BTN-1:0] button_export;
    logic [NUM_SW-1:0]  dipsw_export;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_SW-1:0]  sw_change;
    logic               any_event;

    // Board side: drives the raw pins and observes conditioned results.
    modport master (
        output key_n_raw, sw_raw,
        input  button_export, dipsw_export, btn_press, btn_release, sw_change, any_event
    );

    // Conditioner side.
    modport slave (
        input  key_n_raw, sw_raw,
        output button_export, dipsw_export, btn_press, btn_release, sw_change, any_event
    );
endinterface

// File: rtl/input_debounce_conditioner.sv
// rtl/input_debounce_conditioner.sv - synchronise, debounce and edge-detect buttons and DIP switches
module input_debounce_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic                    clk_clk,
    input logic                    reset_reset,
    input_debounce_conditioner_if.slave bus
);
    localparam int NUM_CH = NUM_BTN + NUM_SW;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Buttons are active-low, so their idle (released) level is 1; switches idle at 0.
    localparam logic [NUM_CH-1:0] RST_LEVEL = {{NUM_SW{1'b0}}, {NUM_BTN{1'b1}}};

    logic [NUM_CH-1:0] raw_all;
    logic [NUM_CH-1:0] stable_all;
    logic [NUM_CH-1:0] accept_all;

    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] release_q;
    logic [NUM_SW-1:0]  change_q;
    logic               any_q;

    assign raw_all = {bus.sw_raw, bus.key_n_raw};

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic                   stable_q;
            logic                   differ;
            logic                   accept;

            assign differ = sync_q[SYNC_STAGES-1] != stable_q;
            assign accept = differ && (cnt_q == CNT_LAST);

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    sync_q   <= {SYNC_STAGES{RST_LEVEL[ch]}};
                    cnt_q    <= '0;
                    stable_q <= RST_LEVEL[ch];
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw_all[ch]};
                    // One cycle agreeing with the stable level restarts qualification.
                    if (!differ) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        stable_q <= sync_q[SYNC_STAGES-1];
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            assign stable_all[ch] = stable_q;
            assign accept_all[ch] = accept;
        end
    endgenerate

    // Strobes are registered on the same edge that flips the stable level.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            press_q   <= '0;
            release_q <= '0;
            change_q  <= '0;
            any_q     <= 1'b0;
        end else begin
            press_q   <= accept_all[NUM_BTN-1:0] &  stable_all[NUM_BTN-1:0];
            release_q <= accept_all[NUM_BTN-1:0] & ~stable_all[NUM_BTN-1:0];
            change_q  <= accept_all[NUM_CH-1:NUM_BTN];
            any_q     <= |accept_all;
        end
    end

    assign bus.button_export = stable_all[NUM_BTN-1:0];
    assign bus.dipsw_export  = stable_all[NUM_CH-1:NUM_BTN];
    assign bus.btn_press     = press_q;
    assign bus.btn_release   = release_q;
    assign bus.sw_change     = change_q;
    assign bus.any_event     = any_q;
endmodule
